// File: rtl/inst_fetch.sv
// inst_fetch: instruction-fetch stage between the PC and ID, with in-order imem requests, a tagged response FIFO and the IF/ID register
// Ports:
//   clk, rst (async, active-low)
//   pc_addr  -> fetch address from the PC;  pc_stall <- hold PC (1) / advance (0)
//   flush    -> redirect; kills every wrong-path request, buffered word and IF/ID entry
//   imem_req/imem_addr <- request;  imem_gnt -> accepted;  imem_rvalid/imem_rdata -> in-order response
//   id_stall -> ID cannot accept;  ifid_valid/ifid_inst/ifid_pc/ifid_pc4 <- IF/ID register
module inst_fetch #(
  parameter int                    WORD_WIDTH = 32,
  parameter logic [WORD_WIDTH-1:0] PC_INIT    = '0,
  parameter int                    MAX_OUTST  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_WIDTH-1:0] pc_addr,
  output logic                  pc_stall,
  input  logic                  flush,
  output logic                  imem_req,
  output logic [WORD_WIDTH-1:0] imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [WORD_WIDTH-1:0] imem_rdata,
  input  logic                  id_stall,
  output logic                  ifid_valid,
  output logic [WORD_WIDTH-1:0] ifid_inst,
  output logic [WORD_WIDTH-1:0] ifid_pc,
  output logic [WORD_WIDTH-1:0] ifid_pc4
);
  localparam int CW = $clog2(MAX_OUTST + 1);
  localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  logic [CW-1:0] outst, drop, fcnt;
  logic [CW:0] occ;
  logic [PW-1:0] tq_wr, tq_rd, f_wr, f_rd;
  logic [WORD_WIDTH-1:0] tq [MAX_OUTST];
  logic [WORD_WIDTH-1:0] fd [MAX_OUTST];
  logic [WORD_WIDTH-1:0] ft [MAX_OUTST];
  logic fire, rsp, discard, deliver, loadable, fempty, pop, push;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
  endfunction
  // credit rule: in-flight plus buffered never exceeds the FIFO depth, so a delivered word always fits
  assign occ       = {1'b0, outst} + {1'b0, fcnt};
  assign imem_req  = rst && !flush && (occ < (CW+1)'(MAX_OUTST));
  assign imem_addr = pc_addr;
  assign fire      = imem_req && imem_gnt;
  assign pc_stall  = !rst || (!fire && !flush);
  // a response with nothing outstanding is stray and ignored
  assign rsp       = imem_rvalid && (outst != '0);
  assign discard   = rsp && (flush || drop != '0);
  assign deliver   = rsp && !discard;
  assign loadable  = !ifid_valid || !id_stall;
  assign fempty    = fcnt == '0;
  assign pop       = !flush && loadable && !fempty;
  // a delivered word bypasses the FIFO only when the FIFO is empty and IF/ID can take it
  assign push      = deliver && !(fempty && loadable);
  assign ifid_pc4  = ifid_pc + WORD_WIDTH'(4);
  always_ff @(posedge clk) begin
    if (fire) tq[tq_wr] <= pc_addr;
    if (push) begin
      fd[f_wr] <= imem_rdata;
      ft[f_wr] <= tq[tq_rd];
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outst      <= '0;
      drop       <= '0;
      tq_wr      <= '0;
      tq_rd      <= '0;
      fcnt       <= '0;
      f_wr       <= '0;
      f_rd       <= '0;
      ifid_valid <= 1'b0;
      ifid_inst  <= '0;
      ifid_pc    <= PC_INIT;
    end else begin
      outst <= outst + CW'(fire) - CW'(rsp);
      // on flush everything still in flight after this cycle becomes wrong-path
      drop  <= flush ? outst - CW'(rsp) : drop - CW'(rsp && drop != '0);
      if (fire) tq_wr <= inc(tq_wr);
      if (rsp) tq_rd <= inc(tq_rd);
      if (flush) begin
        fcnt <= '0;
        f_wr <= '0;
        f_rd <= '0;
      end else begin
        if (push) f_wr <= inc(f_wr);
        if (pop) f_rd <= inc(f_rd);
        fcnt <= fcnt + CW'(push) - CW'(pop);
      end
      if (flush) ifid_valid <= 1'b0;
      else if (loadable) begin
        ifid_valid <= !fempty || deliver;
        if (!fempty) begin
          ifid_inst <= fd[f_rd];
          ifid_pc   <= ft[f_rd];
        end else if (deliver) begin
          ifid_inst <= imem_rdata;
          ifid_pc   <= tq[tq_rd];
        end
      end
    end
  end
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: randomized self-checking bench for inst_fetch against a transaction-level reference model
module tb_inst_fetch;
  logic clk = 1'b0, rst = 1'b0;
  logic [31:0] pc_addr = '0, imem_addr, imem_rdata = '0, ifid_inst, ifid_pc, ifid_pc4;
  logic pc_stall, flush = 1'b0, imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0, id_stall = 1'b0, ifid_valid;
  typedef struct {logic [31:0] a; bit live;} pend_t;
  pend_t pend[$];
  logic [31:0] expq[$];
  int ret_live = 0, n_chk = 0, n_fail = 0;
  int p_gnt = 0, p_rv = 0, p_stall = 0, p_flush = 0;
  bit tgt_en = 0;
  logic [31:0] tgt_fix = '0, tgt = '0, pc_nxt = '0, held;
  logic v, ps, rq;
  always #5 clk = ~clk;
  inst_fetch dut (.clk(clk), .rst(rst), .pc_addr(pc_addr), .pc_stall(pc_stall), .flush(flush),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .id_stall(id_stall), .ifid_valid(ifid_valid), .ifid_inst(ifid_inst),
    .ifid_pc(ifid_pc), .ifid_pc4(ifid_pc4));
  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'h5EED_C0DE;
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic drive();
    imem_gnt = int'($urandom_range(99)) < p_gnt;
    id_stall = int'($urandom_range(99)) < p_stall;
    flush    = int'($urandom_range(99)) < p_flush;
    tgt      = tgt_en ? tgt_fix : ($urandom() & 32'hFFFF_FFFC);
    imem_rvalid = pend.size() != 0 && int'($urandom_range(99)) < p_rv;
    imem_rdata  = imem_rvalid ? mem(pend[0].a) : $urandom();
  endtask
  task automatic set_mode(input int g, input int r, input int s, input int f);
    p_gnt = g; p_rv = r; p_stall = s; p_flush = f;
    drive();
  endtask
  // one clock: check outputs against the model mid-cycle, advance the model, then drive the next inputs
  task automatic step(output logic sv, output logic sps, output logic srq);
    bit fire, cons;
    int fifo_m;
    pend_t p;
    @(negedge clk);
    sv = ifid_valid; sps = pc_stall; srq = imem_req;
    fifo_m = ret_live - ((ret_live > 0) ? 1 : 0);
    check("imem_addr", imem_addr, pc_addr);
    check("ifid_valid", ifid_valid, ret_live > 0);
    check("imem_req", imem_req, !flush && (pend.size() + fifo_m < 2));
    fire = imem_req && imem_gnt;
    check("pc_stall", pc_stall, !fire && !flush);
    cons = ifid_valid && !id_stall && !flush;
    if (cons) begin
      check("stream_nonempty", expq.size() != 0, 1);
      if (expq.size() != 0) begin
        check("ifid_pc", ifid_pc, expq[0]);
        check("ifid_inst", ifid_inst, mem(expq[0]));
        check("ifid_pc4", ifid_pc4, expq[0] + 32'd4);
        void'(expq.pop_front());
        ret_live--;
      end
    end
    if (imem_rvalid && pend.size() != 0) begin
      p = pend.pop_front();
      if (p.live && !flush) ret_live++;
    end
    if (flush) begin
      expq.delete();
      ret_live = 0;
      foreach (pend[i]) pend[i].live = 0;
    end
    if (fire) begin
      pend.push_back('{pc_addr, 1'b1});
      expq.push_back(pc_addr);
    end
    pc_nxt = flush ? tgt : fire ? pc_addr + 32'd4 : pc_addr;
    @(posedge clk);
    #1;
    pc_addr = pc_nxt;
    drive();
  endtask
  task automatic reset_checks(input string tag);
    check({tag, "_valid"}, ifid_valid, 0);
    check({tag, "_inst"}, ifid_inst, 0);
    check({tag, "_pc"}, ifid_pc, 32'h0);
    check({tag, "_pc4"}, ifid_pc4, 32'h4);
    check({tag, "_req"}, imem_req, 0);
    check({tag, "_stall"}, pc_stall, 1);
  endtask
  initial begin
    imem_gnt = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset_checks("rst");
    rst = 1'b1;
    set_mode(100, 100, 0, 0);
    for (int k = 0; k < 10; k++) begin
      step(v, ps, rq);
      if (k >= 2) check("t1_backtoback", v, 1);
      check("t1_pc_stall", ps, 0);
    end
    set_mode(100, 100, 100, 0);
    for (int k = 0; k < 4; k++) begin
      step(v, ps, rq);
      if (k == 3) begin
        check("t2_req_off", rq, 0);
        check("t2_pc_stall", ps, 1);
      end
    end
    set_mode(100, 100, 0, 0);
    repeat (6) step(v, ps, rq);
    set_mode(100, 100, 100, 0);
    step(v, ps, rq);
    tgt_en = 1; tgt_fix = 32'h0000_1000;
    set_mode(100, 100, 100, 100);
    step(v, ps, rq);
    check("t3_flush_kill", ifid_valid, 0);
    set_mode(100, 100, 0, 0);
    repeat (8) step(v, ps, rq);
    set_mode(0, 100, 0, 0);
    repeat (6) step(v, ps, rq);
    held = pc_addr;
    for (int k = 0; k < 3; k++) begin
      step(v, ps, rq);
      check("t4_pc_stall", ps, 1);
      check("t4_req", rq, 1);
      check("t4_pc_held", pc_addr, held);
    end
    set_mode(100, 0, 0, 0);
    repeat (3) step(v, ps, rq);
    #2;
    rst = 1'b0;
    #1;
    reset_checks("t5_rst");
    pend.delete(); expq.delete(); ret_live = 0;
    pc_addr = 32'h0; imem_rvalid = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    set_mode(100, 100, 0, 0);
    repeat (6) step(v, ps, rq);
    tgt_fix = 32'hFFFF_FFFC;
    set_mode(100, 100, 0, 100);
    step(v, ps, rq);
    set_mode(100, 100, 0, 0);
    repeat (2) step(v, ps, rq);
    check("t6_wrap_pc", ifid_pc, 32'hFFFF_FFFC);
    check("t6_wrap_pc4", ifid_pc4, 32'h0000_0000);
    repeat (4) step(v, ps, rq);
    tgt_en = 0;
    set_mode(70, 60, 30, 5);
    repeat (2000) step(v, ps, rq);
    set_mode(0, 100, 0, 0);
    repeat (20) step(v, ps, rq);
    check("drain_empty", expq.size(), 0);
    check("drain_valid", ifid_valid, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
